fmps_trip_monitor: RTL

//  Downstream consumer of fmpsReadLinks in the sysClk domain. After each FA strobe it scans all
//  (1<<INDEX_WIDTH) readout slots, checks every enabled FMPS packet for missing, flagged or

---
 rtl/fmps_trip_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fmps_trip_monitor.sv
// FMPS trip monitor: after each FA strobe, scans every readout slot for missing, flagged or stale
// packets, debounces consecutive bad scans into a sticky trip and latches the first faulty index.
module fmps_trip_monitor #(
   parameter int          INDEX_WIDTH  = 5,
   parameter logic [15:0] OK_MAGIC     = 16'hCACA,
   parameter int          THRESH_WIDTH = 4
) (
   input  logic                          sysClk,
   input  logic                          sysResetN,
   input  logic                          FAstrobe,
   input  logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapAll,
   input  logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapEnabled,
   output logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress,
   input  logic [31:0]                   fmpsReadout,
   input  logic                          csrStrobe,
   input  logic [31:0]                   GPIO_OUT,
   output logic [31:0]                   csr,
   output logic                          tripFlag,
   output logic                          scanDoneStrobe
);

   localparam int SLOTS = 1 << INDEX_WIDTH;
   localparam logic [5:0] CNT_MAX = 6'(SLOTS);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} stateT;

   stateT                    state, stateNext;
   logic [SLOTS-1:0]         allReg, enReg;
   logic [INDEX_WIDTH-1:0]   addrReg;
   logic [7:0]               cycleCounter, scanCc;
   logic [5:0]               scanBad, scanMiss, badCntReg, missCntReg;
   logic                     scanAnyBad;
   logic [INDEX_WIDTH-1:0]   scanFirst, ffIdx;
   logic                     ffValid;
   logic [THRESH_WIDTH-1:0]  badCount, threshold, effThresh, badCountNew;
   logic                     tripReg, overrunReg;
   logic                     slotEnabled, slotMissing, slotBad, lastSlot, csrClear;
   logic                     unusedGpio;

   assign slotEnabled = enReg[addrReg];
   assign slotMissing = slotEnabled && !allReg[addrReg];
   // Word layout: [31:29] error flags, [28:24] slot index, [23:8] magic, [7:0] FA cycle tag
   assign slotBad     = slotEnabled && (slotMissing || (|fmpsReadout[31:29])
                        || fmpsReadout[28:24] != 5'(addrReg)
                        || fmpsReadout[23:8] != OK_MAGIC
                        || fmpsReadout[7:0] != scanCc);
   assign lastSlot    = &addrReg;
   assign csrClear    = csrStrobe && GPIO_OUT[31];
   assign effThresh   = (threshold == '0) ? THRESH_WIDTH'(1) : threshold;
   assign badCountNew = !scanAnyBad ? '0 : ((&badCount) ? badCount : badCount + 1'b1);
   assign unusedGpio  = ^GPIO_OUT[30:THRESH_WIDTH];

   always_ff @(posedge sysClk or negedge sysResetN) begin
      if (!sysResetN) state <= IDLE;
      else            state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (FAstrobe) stateNext = SETTLE;
         SETTLE:  stateNext = CHECK;
         CHECK:   stateNext = lastSlot ? DONE : SETTLE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge sysClk or negedge sysResetN) begin
      if (!sysResetN) begin
         allReg         <= '0;
         enReg          <= '0;
         addrReg        <= '0;
         cycleCounter   <= '0;
         scanCc         <= '0;
         scanBad        <= '0;
         scanMiss       <= '0;
         scanAnyBad     <= 1'b0;
         scanFirst      <= '0;
         badCntReg      <= '0;
         missCntReg     <= '0;
         ffIdx          <= '0;
         ffValid        <= 1'b0;
         badCount       <= '0;
         threshold      <= THRESH_WIDTH'(1);
         tripReg        <= 1'b0;
         overrunReg     <= 1'b0;
         scanDoneStrobe <= 1'b0;
      end else begin
         scanDoneStrobe <= 1'b0;
         if (FAstrobe) cycleCounter <= cycleCounter + 8'd1;
         if (FAstrobe && state != IDLE) overrunReg <= 1'b1;
         if (csrStrobe) threshold <= GPIO_OUT[THRESH_WIDTH-1:0];
         case (state)
            IDLE: if (FAstrobe) begin
               // The scan is tagged with the post-increment counter and keeps it if overrun
               allReg     <= fmpsBitmapAll;
               enReg      <= fmpsBitmapEnabled;
               addrReg    <= '0;
               scanCc     <= cycleCounter + 8'd1;
               scanBad    <= '0;
               scanMiss   <= '0;
               scanAnyBad <= 1'b0;
               scanFirst  <= '0;
            end
            CHECK: begin
               if (slotBad) begin
                  if (!scanAnyBad) scanFirst <= addrReg;
                  scanAnyBad <= 1'b1;
                  scanBad    <= (scanBad == CNT_MAX) ? scanBad : scanBad + 6'd1;
               end
               if (slotMissing) scanMiss <= (scanMiss == CNT_MAX) ? scanMiss : scanMiss + 6'd1;
               if (!lastSlot) addrReg <= addrReg + 1'b1;
            end
            DONE: begin
               scanDoneStrobe <= 1'b1;
               badCntReg      <= scanBad;
               missCntReg     <= scanMiss;
               badCount       <= badCountNew;
               if (badCountNew >= effThresh) tripReg <= 1'b1;
               if (scanAnyBad && !ffValid) begin
                  ffValid <= 1'b1;
                  ffIdx   <= scanFirst;
               end
            end
            default: ;
         endcase
         // Placed last so a software clear overrides a simultaneous scan result
         if (csrClear) begin
            tripReg    <= 1'b0;
            badCount   <= '0;
            ffValid    <= 1'b0;
            overrunReg <= 1'b0;
         end
      end
   end

   assign fmpsReadoutAddress = addrReg;
   assign tripFlag           = tripReg;
   assign csr = {tripReg, overrunReg, ffValid, 5'(ffIdx), 2'b00, badCntReg,
                 2'b00, missCntReg, cycleCounter};

endmodule
